// File: rtl/instr_result_checker_if.sv
// Command, readback and verdict bus between the instruction-register checker and its environment.
interface instr_result_checker_if #(
  parameter int unsigned AW = 5
);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 131;

  logic          start;
  logic [AW-1:0] first_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] read_pointer;
  logic [WW-1:0] instruction_word;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] skip_cnt;
  logic          err_valid;
  logic [AW-1:0] err_ptr;
  logic [63:0]   err_expected;
  logic [63:0]   err_actual;

  modport master (
    output start, first_ptr, count, instruction_word,
    input  read_pointer, busy, done, pass_cnt, fail_cnt, skip_cnt,
           err_valid, err_ptr, err_expected, err_actual
  );

  modport slave (
    input  start, first_ptr, count, instruction_word,
    output read_pointer, busy, done, pass_cnt, fail_cnt, skip_cnt,
           err_valid, err_ptr, err_expected, err_actual
  );
endinterface

// File: rtl/instr_result_checker.sv
// Walks a window of instruction-register entries, recomputes each stored result
// with an independent reference model and counts pass/fail/skip verdicts.
module instr_result_checker #(
  parameter int unsigned AW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_result_checker_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 131;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [WW-1:0] cap;

  logic [2:0]         op;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [63:0]        stored;
  logic signed [63:0] a64;
  logic signed [63:0] b64;
  logic signed [31:0] b_safe_c;
  logic signed [31:0] quo_c;
  logic signed [31:0] rem_c;
  logic [63:0]        model_c;
  logic               skip_c;

  assign op     = cap[130:128];
  assign a      = cap[127:96];
  assign b      = cap[95:64];
  assign stored = cap[63:0];
  assign a64    = {{32{a[31]}}, a};
  assign b64    = {{32{b[31]}}, b};

  // Reference model; b=-1 is handled without a divider so -2^31/-1 wraps to -2^31.
  always_comb begin
    model_c  = '0;
    skip_c   = 1'b0;
    b_safe_c = (b == 32'sd0) ? 32'sd1 : b;
    if (b == -32'sd1) begin
      quo_c = -a;
      rem_c = '0;
    end else begin
      quo_c = a / b_safe_c;
      rem_c = a % b_safe_c;
    end
    case (op)
      OP_ZERO:  model_c = '0;
      OP_PASSA: model_c = a64;
      OP_PASSB: model_c = b64;
      OP_ADD:   model_c = a64 + b64;
      OP_SUB:   model_c = a64 - b64;
      OP_MULT:  model_c = a64 * b64;
      OP_DIV: begin
        model_c = {{32{quo_c[31]}}, quo_c};
        skip_c  = (b == 32'sd0);
      end
      OP_MOD: begin
        model_c = {{32{rem_c[31]}}, rem_c};
        skip_c  = (b == 32'sd0);
      end
      default: model_c = '0;
    endcase
  end

  // Window-walking FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      remaining        <= '0;
      cap              <= '0;
      bus.read_pointer <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass_cnt     <= '0;
      bus.fail_cnt     <= '0;
      bus.skip_cnt     <= '0;
      bus.err_valid    <= 1'b0;
      bus.err_ptr      <= '0;
      bus.err_expected <= '0;
      bus.err_actual   <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.read_pointer <= bus.first_ptr;
            remaining        <= bus.count;
            bus.pass_cnt     <= '0;
            bus.fail_cnt     <= '0;
            bus.skip_cnt     <= '0;
            bus.busy         <= 1'b1;
            state            <= (bus.count != '0) ? CAPTURE : DONE;
          end
        end
        CAPTURE: begin
          cap   <= bus.instruction_word;
          state <= COMPARE;
        end
        COMPARE: begin
          if (skip_c) begin
            bus.skip_cnt <= bus.skip_cnt + CW'(1);
          end else if (model_c == stored) begin
            bus.pass_cnt <= bus.pass_cnt + CW'(1);
          end else begin
            bus.fail_cnt     <= bus.fail_cnt + CW'(1);
            bus.err_valid    <= 1'b1;
            bus.err_ptr      <= bus.read_pointer;
            bus.err_expected <= model_c;
            bus.err_actual   <= stored;
          end
          bus.read_pointer <= bus.read_pointer + AW'(1);
          remaining        <= remaining - CW'(1);
          state            <= (remaining == CW'(1)) ? DONE : CAPTURE;
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_result_checker.sv
// Directed bench for instr_result_checker: single-entry vector table plus window sequences.
module tb_instr_result_checker;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  instr_result_checker_if #(.AW(5)) bus ();
  instr_result_checker #(.AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [130:0] mem [32];
  assign bus.instruction_word = mem[bus.read_pointer];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [63:0] model;
    logic [5:0]  ep;
    logic [5:0]  ef;
    logic [5:0]  es;
  } vec_t;

  vec_t vecs [12];

  int          done_edge;
  int          err_cnt;
  int          err_edge;
  logic [4:0]  s_eptr;
  logic [63:0] s_eexp;
  logic [63:0] s_eact;
  logic        s_busy0;
  logic        s_busy_done;
  logic [4:0]  ptr_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [130:0] mk(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [63:0] res);
    return {op, a, b, res};
  endfunction

  // Start a window and follow it to done; optionally re-pulse start at edge restart_at.
  task automatic run_window(input logic [4:0] fp, input logic [5:0] cnt, input int restart_at);
    @(negedge clk);
    bus.start = 1'b1; bus.first_ptr = fp; bus.count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.first_ptr = '0; bus.count = '0;
    ptr_q = {};
    ptr_q.push_back(bus.read_pointer);
    s_busy0 = bus.busy;
    done_edge = -1; err_cnt = 0; err_edge = -1;
    for (int e = 1; e <= 200 && done_edge < 0; e++) begin
      if (e == restart_at) begin
        bus.start = 1'b1; bus.first_ptr = 5'd9; bus.count = 6'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.first_ptr = '0; bus.count = '0;
      if (bus.err_valid) begin
        err_cnt++; err_edge = e;
        s_eptr = bus.err_ptr; s_eexp = bus.err_expected; s_eact = bus.err_actual;
      end
      if (bus.done) begin
        done_edge = e; s_busy_done = bus.busy;
      end
      if (e % 2 == 0 && e < 2 * int'(cnt)) ptr_q.push_back(bus.read_pointer);
    end
    if (done_edge < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: got none expected done within 200 cycles");
    end
  endtask

  initial begin
    logic [63:0] neg_prod;
    neg_prod = -64'sd1600000000;

    vecs[0]  = '{3'd0, 32'd7,          32'd9,          64'd0,                  64'd0,                  6'd1, 6'd0, 6'd0};
    vecs[1]  = '{3'd0, 32'd7,          32'd9,          64'd1,                  64'd0,                  6'd0, 6'd1, 6'd0};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFB,  32'd3,          64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 6'd1, 6'd0, 6'd0};
    vecs[3]  = '{3'd2, 32'd1,          32'h8000_0000,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 6'd1, 6'd0, 6'd0};
    vecs[4]  = '{3'd3, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE, 6'd1, 6'd0, 6'd0};
    vecs[5]  = '{3'd4, 32'd0,          32'h8000_0000,  64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 6'd1, 6'd0, 6'd0};
    vecs[6]  = '{3'd5, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 6'd1, 6'd0, 6'd0};
    vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 6'd1, 6'd0, 6'd0};
    vecs[8]  = '{3'd7, 32'd7,          32'hFFFF_FFFD,  64'd1,                  64'd1,                  6'd1, 6'd0, 6'd0};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,          64'd123,                64'd0,                  6'd0, 6'd0, 6'd1};
    vecs[10] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFD, 6'd0, 6'd1, 6'd0};
    vecs[11] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF,  64'd0,                  64'd0,                  6'd1, 6'd0, 6'd0};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.start = 1'b0; bus.first_ptr = '0; bus.count = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.busy, bus.done, bus.err_valid, bus.read_pointer,
                        bus.pass_cnt, bus.fail_cnt, bus.skip_cnt, bus.err_ptr}, '0);
    chk("rst_err_data", bus.err_expected | bus.err_actual, '0);
    @(negedge clk);
    reset = 1'b0;

    // Single-entry vector table at entry 10.
    for (int i = 0; i < 12; i++) begin
      mem[10] = mk(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
      run_window(5'd10, 6'd1, 0);
      chk($sformatf("vec%0d_done_edge", i), 64'(done_edge), 64'd3);
      chk($sformatf("vec%0d_counts", i), {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt},
          {vecs[i].ep, vecs[i].ef, vecs[i].es});
      chk($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(vecs[i].ef));
      if (vecs[i].ef != 0)
        chk($sformatf("vec%0d_err_data", i), {s_eptr, s_eexp ^ vecs[i].model, s_eact ^ vecs[i].res}, {5'd10, 128'd0});
    end

    // ADD pass, single entry.
    mem[0] = mk(3'd3, 32'd5, 32'hFFFF_FFFD, 64'd2);
    run_window(5'd0, 6'd1, 0);
    chk("t1_done_edge", 64'(done_edge), 64'd3);
    chk("t1_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, {6'd1, 6'd0, 6'd0});
    chk("t1_err_cnt", 64'(err_cnt), 64'd0);
    chk("t1_busy", {s_busy0, s_busy_done}, 2'b10);

    // MULT pass then SUB fail.
    mem[4] = mk(3'd5, 32'd40000, 32'hFFFF_63C0, neg_prod);
    mem[5] = mk(3'd4, 32'h8000_0000, 32'd1, 64'd0);
    run_window(5'd4, 6'd2, 0);
    chk("t2_done_edge", 64'(done_edge), 64'd5);
    chk("t2_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, {6'd1, 6'd1, 6'd0});
    chk("t2_err_edge", 64'(err_edge), 64'd4);
    chk("t2_err_ptr", 64'(s_eptr), 64'd5);
    chk("t2_err_expected", s_eexp, 64'hFFFF_FFFF_7FFF_FFFF);
    chk("t2_err_actual", s_eact, 64'd0);

    // Same window with a start pulse mid-window that must be ignored.
    run_window(5'd4, 6'd2, 2);
    chk("t6_done_edge", 64'(done_edge), 64'd5);
    chk("t6_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, {6'd1, 6'd1, 6'd0});
    chk("t6_err_edge", 64'(err_edge), 64'd4);
    chk("t6_err_ptr", 64'(s_eptr), 64'd5);
    chk("t6_ptr_seq", {ptr_q.size() == 2 ? ptr_q[0] : 5'd0, ptr_q.size() == 2 ? ptr_q[1] : 5'd0}, {5'd4, 5'd5});

    // Wrap-around window 31,0,1 with a divide-by-zero skip.
    mem[31] = mk(3'd6, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    mem[0]  = mk(3'd7, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    mem[1]  = mk(3'd6, 32'd9, 32'd0, 64'd0);
    run_window(5'd31, 6'd3, 0);
    chk("t3_done_edge", 64'(done_edge), 64'd7);
    chk("t3_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, {6'd2, 6'd0, 6'd1});
    chk("t3_ptr_len", 64'(ptr_q.size()), 64'd3);
    if (ptr_q.size() == 3) chk("t3_ptr_seq", {ptr_q[0], ptr_q[1], ptr_q[2]}, {5'd31, 5'd0, 5'd1});

    // Full 32-entry window starting mid-register, one bad entry.
    for (int i = 0; i < 32; i++) mem[i] = mk(3'd1, 32'hFFFF_FFFF, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    mem[17] = mk(3'd1, 32'hFFFF_FFFF, 32'd0, 64'h7FFF_FFFF_FFFF_FFFF);
    run_window(5'd20, 6'd32, 0);
    chk("t4_done_edge", 64'(done_edge), 64'd65);
    chk("t4_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, {6'd31, 6'd1, 6'd0});
    chk("t4_err_ptr", 64'(s_eptr), 64'd17);
    chk("t4_err_cnt", 64'(err_cnt), 64'd1);
    chk("t4_ptr_len", 64'(ptr_q.size()), 64'd32);

    // Reset in the middle of a count=8 window, then a count=0 window.
    @(negedge clk);
    bus.start = 1'b1; bus.first_ptr = 5'd3; bus.count = 6'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_reset_state", {bus.busy, bus.done, bus.err_valid, bus.read_pointer,
                           bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, '0);
    reset = 1'b0;
    run_window(5'd7, 6'd0, 0);
    chk("t5_zero_done_edge", 64'(done_edge), 64'd1);
    chk("t5_zero_counts", {bus.pass_cnt, bus.fail_cnt, bus.skip_cnt}, '0);
    chk("t5_zero_busy", {s_busy0, s_busy_done}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
